// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants, GAMMA table and basemul FSM states
package kyber_pkg;

    localparam int Q_MOD         = 3329;
    localparam int BARRETT_V     = 5039;
    localparam int BARRETT_SHIFT = 24;
    localparam int POLY_WORDS    = 32;
    localparam int POLY_LANES    = 8;
    localparam int COEF_W        = 12;
    localparam int GAMMA_N       = 128;
    localparam int GAMMA_IDX_W   = $clog2(GAMMA_N);

    typedef logic [GAMMA_N-1:0][COEF_W-1:0] gamma_tab_t;

    // GAMMA[k] = 17^(2*br7(k)+1) mod Q, normal (non-Montgomery) domain
    function automatic gamma_tab_t gen_gamma();
        gamma_tab_t tab;
        int         br;
        int         e;
        int         base;
        int         acc;
        tab = '0;
        for (int k = 0; k < GAMMA_N; k++) begin
            br = 0;
            for (int i = 0; i < 7; i++) begin
                if (((k >> i) & 1) != 0) begin
                    br = br | (1 << (6 - i));
                end
            end
            e    = 2 * br + 1;
            base = 17;
            acc  = 1;
            for (int i = 0; i < 8; i++) begin
                if (((e >> i) & 1) != 0) begin
                    acc = (acc * base) % Q_MOD;
                end
                base = (base * base) % Q_MOD;
            end
            tab[GAMMA_IDX_W'(k)] = COEF_W'(acc);
        end
        return tab;
    endfunction

    localparam gamma_tab_t GAMMA = gen_gamma();

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/basemul_pair.sv
// rtl/basemul_pair.sv - four-stage pipelined base-case multiply of one coefficient pair
module basemul_pair
    import kyber_pkg::*;
#(
    parameter int Q = Q_MOD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  stage_en,
    input  logic [11:0] a0,
    input  logic [11:0] a1,
    input  logic [11:0] b0,
    input  logic [11:0] b1,
    input  logic [11:0] gamma,
    output logic [15:0] c0,
    output logic [15:0] c1
);

    // Inputs stay below 2^24.4, so the quotient estimate is at most one low
    // and a single conditional subtraction gives the canonical residue.
    function automatic logic [11:0] barrett(input logic [24:0] x);
        logic [37:0] prod;
        logic [13:0] qt;
        logic [25:0] r;
        prod = 38'(x) * 38'(BARRETT_V);
        qt   = 14'(prod >> BARRETT_SHIFT);
        r    = 26'(x) - 26'(qt) * 26'(Q);
        if (r >= 26'(Q)) begin
            r = r - 26'(Q);
        end
        return 12'(r);
    endfunction

    logic [23:0] p00_q, p00_d, p11_q, p11_d, p01_q, p01_d, p10_q, p10_d;
    logic [11:0] g1_q, g1_d;
    logic [11:0] t11_q, t11_d, g2_q, g2_d;
    logic [23:0] p00b_q, p00b_d;
    logic [24:0] c1s_q, c1s_d;
    logic [24:0] s0_q, s0_d;
    logic [11:0] c1r_q, c1r_d;
    logic [11:0] c0o_q, c0o_d, c1o_q, c1o_d;

    // Each stage only advances when its word is valid, so the output holds between words
    always_comb begin
        p00_d  = p00_q;
        p11_d  = p11_q;
        p01_d  = p01_q;
        p10_d  = p10_q;
        g1_d   = g1_q;
        t11_d  = t11_q;
        p00b_d = p00b_q;
        c1s_d  = c1s_q;
        g2_d   = g2_q;
        s0_d   = s0_q;
        c1r_d  = c1r_q;
        c0o_d  = c0o_q;
        c1o_d  = c1o_q;
        if (stage_en[0]) begin
            p00_d = 24'(a0) * 24'(b0);
            p11_d = 24'(a1) * 24'(b1);
            p01_d = 24'(a0) * 24'(b1);
            p10_d = 24'(a1) * 24'(b0);
            g1_d  = gamma;
        end
        if (stage_en[1]) begin
            t11_d  = barrett(25'(p11_q));
            p00b_d = p00_q;
            c1s_d  = 25'(p01_q) + 25'(p10_q);
            g2_d   = g1_q;
        end
        if (stage_en[2]) begin
            s0_d  = 25'(p00b_q) + 25'(t11_q) * 25'(g2_q);
            c1r_d = barrett(c1s_q);
        end
        if (stage_en[3]) begin
            c0o_d = barrett(s0_q);
            c1o_d = c1r_q;
        end
    end

    // Pipeline registers, cleared by reset so the output word reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            p00_q  <= '0;
            p11_q  <= '0;
            p01_q  <= '0;
            p10_q  <= '0;
            g1_q   <= '0;
            t11_q  <= '0;
            p00b_q <= '0;
            c1s_q  <= '0;
            g2_q   <= '0;
            s0_q   <= '0;
            c1r_q  <= '0;
            c0o_q  <= '0;
            c1o_q  <= '0;
        end else begin
            p00_q  <= p00_d;
            p11_q  <= p11_d;
            p01_q  <= p01_d;
            p10_q  <= p10_d;
            g1_q   <= g1_d;
            t11_q  <= t11_d;
            p00b_q <= p00b_d;
            c1s_q  <= c1s_d;
            g2_q   <= g2_d;
            s0_q   <= s0_d;
            c1r_q  <= c1r_d;
            c0o_q  <= c0o_d;
            c1o_q  <= c1o_d;
        end
    end

    assign c0 = {4'b0000, c0o_q};
    assign c1 = {4'b0000, c1o_q};

endmodule

// File: rtl/ntt_basemul_stream.sv
// rtl/ntt_basemul_stream.sv - streaming NTT-domain pointwise multiplier; BASEMUL_OUT_REG_EN adds an output register stage
module ntt_basemul_stream
    import kyber_pkg::*;
#(
    parameter int Q     = Q_MOD,
    parameter int WORDS = POLY_WORDS,
    parameter int LANES = POLY_LANES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [16*LANES-1:0]  a_data,
    input  logic [16*LANES-1:0]  b_data,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic [16*LANES-1:0]  data_out,
    output logic                 valid_out,
    output logic                 done
);

    localparam int PAIRS  = LANES / 2;
    localparam int WCNT_W = $clog2(WORDS);
    localparam int OCNT_W = $clog2(WORDS + 1);
    localparam int GIDX_W = GAMMA_IDX_W;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [OCNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [3:0]          vld_q, vld_d;
    logic                accept;
    logic [3:0]          stage_en;
    logic [16*LANES-1:0] pipe_data;

    assign stage_en = {vld_q[2:0], accept};

    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        logic [GIDX_W-1:0] gidx;
        logic [15:0]       c0;
        logic [15:0]       c1;
        logic              unused_hi;

        // Coefficients are < Q, so the top nibble of every lane is dropped
        assign unused_hi = ^{a_data[32*p+12 +: 4], a_data[32*p+28 +: 4],
                             b_data[32*p+12 +: 4], b_data[32*p+28 +: 4]};
        assign gidx      = GIDX_W'(int'(word_cnt_q) * PAIRS + p);

        basemul_pair #(
            .Q(Q)
        ) u_pair (
            .clk      (clk),
            .rst      (rst),
            .stage_en (stage_en),
            .a0       (a_data[32*p +: 12]),
            .a1       (a_data[32*p+16 +: 12]),
            .b0       (b_data[32*p +: 12]),
            .b1       (b_data[32*p+16 +: 12]),
            .gamma    (GAMMA[gidx]),
            .c0       (c0),
            .c1       (c1)
        );

        assign pipe_data[32*p +: 32] = {c1, c0};
    end

`ifdef BASEMUL_OUT_REG_EN
    logic [16*LANES-1:0] out_data_q, out_data_d;
    logic                out_vld_q, out_vld_d;

    // Extra output stage: captures a finished word, holds it otherwise
    always_comb begin
        out_vld_d  = vld_q[3];
        out_data_d = vld_q[3] ? pipe_data : out_data_q;
    end

    // Output stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign data_out  = out_data_q;
    assign valid_out = out_vld_q;
`else
    assign data_out  = pipe_data;
    assign valid_out = vld_q[3];
`endif

    // FSM next state, word/drain counters and the valid shift register
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        out_cnt_d  = valid_out ? out_cnt_q + 1'b1 : out_cnt_q;
        accept     = 1'b0;
        ready_in   = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                word_cnt_d = '0;
                out_cnt_d  = '0;
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ready_in = 1'b1;
                accept   = valid_in;
                if (valid_in) begin
                    if (word_cnt_q == WCNT_W'(WORDS - 1)) begin
                        word_cnt_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (valid_out && out_cnt_q == OCNT_W'(WORDS - 1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done      = 1'b1;
                out_cnt_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        vld_d = {vld_q[2:0], accept};
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            out_cnt_q  <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            out_cnt_q  <= out_cnt_d;
            vld_q      <= vld_d;
        end
    end

endmodule

// File: tb/tb_ntt_basemul_stream.sv
// tb/tb_ntt_basemul_stream.sv - scoreboard bench for ntt_basemul_stream
module tb_ntt_basemul_stream;

    localparam int QM = 3329;
`ifdef BASEMUL_OUT_REG_EN
    localparam int L = 5;
`else
    localparam int L = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         valid_in;
    logic         ready_in;
    logic         valid_out;
    logic         done;
    logic [127:0] a_data;
    logic [127:0] b_data;
    logic [127:0] data_out;

    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           out_count = 0;
    int           done_count = 0;
    int           done_cyc = -1;
    bit           mon_en = 1'b0;
    logic [127:0] last_out = '0;
    logic [127:0] exp_q[$];
    int           acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_basemul_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_data    (a_data),
        .b_data    (b_data),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .done      (done)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int gamma_of(input int k);
        int br;
        int acc;
        br = 0;
        for (int i = 0; i < 7; i++) begin
            if (((k >> i) & 1) != 0) br = br | (1 << (6 - i));
        end
        acc = 1;
        for (int i = 0; i < 2 * br + 1; i++) acc = (acc * 17) % QM;
        return acc;
    endfunction

    function automatic logic [127:0] model_word(input logic [127:0] a, input logic [127:0] b, input int w);
        logic [127:0] r;
        int a0, a1, b0, b1, c0, c1;
        r = '0;
        for (int p = 0; p < 4; p++) begin
            a0 = int'(a[32*p +: 16]);
            a1 = int'(a[32*p+16 +: 16]);
            b0 = int'(b[32*p +: 16]);
            b1 = int'(b[32*p+16 +: 16]);
            c0 = (a0 * b0 + ((a1 * b1) % QM) * gamma_of(4 * w + p)) % QM;
            c1 = (a0 * b1 + a1 * b0) % QM;
            r[32*p +: 16]    = 16'(c0);
            r[32*p+16 +: 16] = 16'(c1);
        end
        return r;
    endfunction

    // Scoreboard monitor: pops the expected word whenever the DUT presents one
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid_out: got word %0h expected none at cycle %0d", data_out, cyc);
                end else begin
                    chk("data_out", data_out, exp_q.pop_front());
                    chk("out_latency", 128'(cyc), 128'(acc_q.pop_front() + L - 1));
                    out_count++;
                end
                last_out = data_out;
            end else begin
                chk("data_hold", data_out, last_out);
            end
            if (done === 1'b1) begin
                done_count++;
                done_cyc = cyc;
            end
            if (rst === 1'b1) last_out = '0;
        end
    end

    // mode: 0 identity, 1 gamma, 2 extremes, 3 random
    task automatic run_poly(input int mode, input int bubble, input int spurious, input int nwords);
        int           t, sent, last_acc, oc0, dc0, guard;
        logic [127:0] a, b, e;
        bit           dv;
        oc0 = out_count;
        dc0 = done_count;
        start = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        start = 1'b0;
        chk("ready_after_start", 128'(ready_in), 128'(1));
        sent = 0;
        last_acc = 0;
        while (sent < nwords) begin
            dv = (bubble != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            case (mode)
                0: begin
                    a = {4{16'd0, 16'd1}};
                    for (int j = 0; j < 8; j++) b[16*j +: 16] = 16'((sent * 211 + j * 37 + 3) % QM);
                    e = b;
                end
                1: begin
                    a = {4{16'd1, 16'd0}};
                    b = a;
                    e = model_word(a, b, sent);
                    if (sent == 0) e[63:0] = {16'd0, 16'd3312, 16'd0, 16'd17};
                end
                2: begin
                    a = {8{16'd3328}};
                    b = a;
                    e = model_word(a, b, sent);
                    if (sent == 0) e[63:0] = {16'd2, 16'd3313, 16'd2, 16'd18};
                end
                default: begin
                    for (int j = 0; j < 8; j++) begin
                        a[16*j +: 16] = 16'($urandom_range(0, QM - 1));
                        b[16*j +: 16] = 16'($urandom_range(0, QM - 1));
                    end
                    e = model_word(a, b, sent);
                end
            endcase
            a_data   = dv ? a : {$urandom, $urandom, $urandom, $urandom};
            b_data   = dv ? b : {$urandom, $urandom, $urandom, $urandom};
            valid_in = dv;
            start    = (spurious != 0 && sent == 5) ? 1'b1 : 1'b0;
            if (dv) exp_q.push_back(e);
            @(posedge clk); #1;
            if (dv) begin
                acc_q.push_back(cyc);
                last_acc = cyc;
                sent++;
            end
        end
        valid_in = 1'b0;
        start = 1'b0;
        if (nwords < 32) return;
        if (spurious != 0) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        guard = 0;
        while (done_count == dc0 && guard < 300) begin
            @(posedge clk); #1;
            start = (spurious != 0 && done === 1'b1) ? 1'b1 : 1'b0;
            guard++;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 128'(done_count - dc0), 128'(1));
        chk("done_after_last_word", 128'(done_cyc), 128'(last_acc + L));
        if (bubble == 0) chk("done_from_start", 128'(done_cyc), 128'(t + 32 + L));
        chk("out_words", 128'(out_count - oc0), 128'(32));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        chk("idle_after_done", 128'(ready_in), 128'(0));
    endtask

    initial begin
        int dc0, oc0;
        rst = 1'b1;
        start = 1'b0;
        valid_in = 1'b0;
        a_data = '0;
        b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_in", 128'(ready_in), 128'(0));
        chk("rst_valid_out", 128'(valid_out), 128'(0));
        chk("rst_data_out", data_out, 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst = 1'b0;
        mon_en = 1'b1;

        valid_in = 1'b1;
        a_data = {8{16'd5}};
        b_data = {8{16'd7}};
        repeat (5) @(posedge clk);
        #1;
        valid_in = 1'b0;
        chk("idle_ignores_valid", 128'(ready_in), 128'(0));

        run_poly(0, 0, 0, 32);
        run_poly(1, 0, 0, 32);
        run_poly(2, 0, 0, 32);
        run_poly(3, 1, 0, 32);

        run_poly(3, 0, 0, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        acc_q.delete();
        chk("midrst_ready_in", 128'(ready_in), 128'(0));
        chk("midrst_valid_out", 128'(valid_out), 128'(0));
        chk("midrst_data_out", data_out, 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        rst = 1'b0;
        dc0 = done_count;
        oc0 = out_count;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_done", 128'(done_count), 128'(dc0));
        chk("midrst_no_output", 128'(out_count), 128'(oc0));

        run_poly(3, 0, 0, 32);
        run_poly(3, 1, 1, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
